// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generation stage: format codes,
// RV32/RV64 base opcodes and the skid-buffer state encoding.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_SH  = 3'd2,
      FMT_S   = 3'd3,
      FMT_B   = 3'd4,
      FMT_U   = 3'd5,
      FMT_J   = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   // OP-IMM with funct3 SLLI/SRLI/SRAI carries a shift amount, not an immediate.
   function automatic logic is_shift_funct3(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational RV instruction format decode and immediate extension.
// Optional feature macro: IMM_GEN_UJ_EN -- when defined, LUI/AUIPC decode as U
// and JAL as J; otherwise those opcodes report ILL with a zero immediate.
module imm_gen_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o,
   output fmt_e            fmt_o
);

   localparam bit IS_RV64 = (XLEN == 64);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [5:0]  shamt;
   logic [31:0] imm32;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   // RV64 shifts use a 6-bit shamt; RV32 only 5 bits (bit 25 belongs to funct7).
   assign shamt  = IS_RV64 ? instr_i[25:20] : {1'b0, instr_i[24:20]};

   // Classify the instruction from its opcode (and funct3 for shifts).
   always_comb begin
      fmt_o = FMT_ILL;
      case (opcode)
         OP_OP:              fmt_o = FMT_R;
         OP_IMM:             fmt_o = is_shift_funct3(funct3) ? FMT_SH : FMT_I;
         OP_LOAD, OP_JALR:   fmt_o = FMT_I;
         OP_STORE:           fmt_o = FMT_S;
         OP_BRANCH:          fmt_o = FMT_B;
`ifdef IMM_GEN_UJ_EN
         OP_LUI, OP_AUIPC:   fmt_o = FMT_U;
         OP_JAL:             fmt_o = FMT_J;
`else
         OP_LUI, OP_AUIPC,
         OP_JAL:             fmt_o = FMT_ILL;
`endif
         default:            fmt_o = FMT_ILL;
      endcase
   end

   // Assemble a 32-bit immediate, then replicate bit 31 up to XLEN.
   // Shift amounts have bit 31 clear, so the same step zero-extends them.
   always_comb begin
      imm32 = '0;
      case (fmt_o)
         FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         FMT_SH:  imm32 = {26'b0, shamt};
         FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         FMT_U:   imm32 = {instr_i[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm_o        = {XLEN{imm32[31]}};
      imm_o[31:0]  = imm32;
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes each accepted instruction and
// holds results in a 2-entry in-order skid buffer.
// XLEN must be 32 or 64. Optional feature macro: IMM_GEN_UJ_EN (see imm_gen_decode).
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no entry held; out_valid_o low
// ST_ONE   | head entry valid; can still accept one more
// ST_FULL  | head and tail valid; in_ready_o low
module imm_gen_stage
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      fmt_o
);

   state_e          state_q, state_nxt;
   logic            ready_q;
   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic [XLEN-1:0] head_imm_q, tail_imm_q;
   fmt_e            head_fmt_q, tail_fmt_q;
   logic            push, pop;
   logic            load_head_dec, load_head_tail, load_tail;

   imm_gen_decode #(.XLEN(XLEN)) u_decode (
      .instr_i (instr_i),
      .imm_o   (dec_imm),
      .fmt_o   (dec_fmt)
   );

   assign push        = in_valid_i & ready_q;
   assign pop         = out_valid_o & out_ready_i;
   assign in_ready_o  = ready_q;
   assign out_valid_o = (state_q != ST_EMPTY);
   assign imm_o       = head_imm_q;
   assign fmt_o       = head_fmt_q;

   // State register; ready is registered from next state so it never
   // depends combinationally on out_ready_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_nxt;
         ready_q <= (state_nxt != ST_FULL);
      end
   end

   // Next state and buffer steering; flush overrides any push or pop.
   always_comb begin
      state_nxt      = state_q;
      load_head_dec  = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
      if (flush_i) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_nxt     = ST_ONE;
                  load_head_dec = 1'b1;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  load_head_dec = 1'b1;
               end else if (push) begin
                  state_nxt = ST_FULL;
                  load_tail = 1'b1;
               end else if (pop) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_nxt      = ST_ONE;
                  load_head_tail = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Head entry drives the outputs; cleared on reset and flush so no stale
   // immediate lingers on imm_o.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         head_imm_q <= '0;
         head_fmt_q <= FMT_R;
      end else if (load_head_dec) begin
         head_imm_q <= dec_imm;
         head_fmt_q <= dec_fmt;
      end else if (load_head_tail) begin
         head_imm_q <= tail_imm_q;
         head_fmt_q <= tail_fmt_q;
      end
   end

   // Tail entry holds the second-oldest result while the head is stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tail_imm_q <= '0;
         tail_fmt_q <= FMT_R;
      end else if (load_tail) begin
         tail_imm_q <= dec_imm;
         tail_fmt_q <= dec_fmt;
      end
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance.
// Expected U/J results follow the IMM_GEN_UJ_EN build macro.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // XLEN=32 instance signals
   logic        rst, fl, iv, ordy;
   logic [31:0] ins;
   logic        irdy, ov;
   logic [31:0] imm;
   logic [2:0]  fmt;

   // XLEN=64 instance signals
   logic        rst64, fl64, iv64, ordy64;
   logic [31:0] ins64;
   logic        irdy64, ov64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef IMM_GEN_UJ_EN
   localparam logic [63:0] LUI_IMM = 64'h12345000;
   localparam logic [63:0] LUI_FMT = 64'd5;
   localparam logic [63:0] JAL_IMM = 64'hFFFFFFFC;
   localparam logic [63:0] JAL_FMT = 64'd6;
`else
   localparam logic [63:0] LUI_IMM = 64'h0;
   localparam logic [63:0] LUI_FMT = 64'd7;
   localparam logic [63:0] JAL_IMM = 64'h0;
   localparam logic [63:0] JAL_FMT = 64'd7;
`endif

   imm_gen_stage #(.XLEN(32)) u_dut32 (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (fl),
      .in_valid_i  (iv),
      .in_ready_o  (irdy),
      .instr_i     (ins),
      .out_valid_o (ov),
      .out_ready_i (ordy),
      .imm_o       (imm),
      .fmt_o       (fmt)
   );

   imm_gen_stage #(.XLEN(64)) u_dut64 (
      .clk_i       (clk),
      .rst_i       (rst64),
      .flush_i     (fl64),
      .in_valid_i  (iv64),
      .in_ready_o  (irdy64),
      .instr_i     (ins64),
      .out_valid_o (ov64),
      .out_ready_i (ordy64),
      .imm_o       (imm64),
      .fmt_o       (fmt64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; fl = 1'b0; iv = 1'b0; ordy = 1'b0; ins = '0;
      rst64 = 1'b1; fl64 = 1'b0; iv64 = 1'b0; ordy64 = 1'b0; ins64 = '0;
      step();
      step();
      rst = 1'b0; rst64 = 1'b0;

      // reset state
      chk("rst_ov", {63'b0, ov}, 64'd0);
      chk("rst_irdy", {63'b0, irdy}, 64'd1);
      chk("rst_imm", {32'b0, imm}, 64'd0);
      chk("rst_fmt", {61'b0, fmt}, 64'd0);
      chk("rst64_irdy", {63'b0, irdy64}, 64'd1);

      // addi -1, latency 1
      ordy = 1'b1; iv = 1'b1; ins = 32'hFFF00093;
      step();
      iv = 1'b0;
      chk("addi_ov", {63'b0, ov}, 64'd1);
      chk("addi_imm", {32'b0, imm}, 64'hFFFFFFFF);
      chk("addi_fmt", {61'b0, fmt}, 64'd1);
      step();
      chk("addi_drain", {63'b0, ov}, 64'd0);

      // beq -4 followed immediately by srai 5 (one transfer per cycle)
      iv = 1'b1; ins = 32'hFE000EE3;
      step();
      chk("beq_imm", {32'b0, imm}, 64'hFFFFFFFC);
      chk("beq_fmt", {61'b0, fmt}, 64'd4);
      ins = 32'h40515093;
      step();
      iv = 1'b0;
      chk("srai_imm", {32'b0, imm}, 64'd5);
      chk("srai_fmt", {61'b0, fmt}, 64'd2);
      chk("srai_ov", {63'b0, ov}, 64'd1);
      step();
      chk("srai_drain", {63'b0, ov}, 64'd0);

      // RV32 slli with bit 25 set: only 5 shamt bits used
      iv = 1'b1; ins = 32'h03F01013;
      step();
      chk("slli32_imm", {32'b0, imm}, 64'h1F);
      // add (R) and all-zero word (ILL)
      ins = 32'h002081B3;
      step();
      chk("add_imm", {32'b0, imm}, 64'd0);
      chk("add_fmt", {61'b0, fmt}, 64'd0);
      ins = 32'h00000000;
      step();
      iv = 1'b0;
      chk("ill_fmt", {61'b0, fmt}, 64'd7);
      chk("ill_imm", {32'b0, imm}, 64'd0);
      step();

      // backpressure: three pushes with out_ready low
      ordy = 1'b0; iv = 1'b1; ins = 32'h00500113;
      step();
      chk("bp1_irdy", {63'b0, irdy}, 64'd1);
      chk("bp1_imm", {32'b0, imm}, 64'd5);
      ins = 32'h0040A423;
      step();
      chk("bp2_irdy", {63'b0, irdy}, 64'd0);
      chk("bp2_imm", {32'b0, imm}, 64'd5);
      ins = 32'hFE40AC23;
      step();
      chk("bp3_irdy", {63'b0, irdy}, 64'd0);
      chk("bp3_hold_imm", {32'b0, imm}, 64'd5);
      chk("bp3_hold_fmt", {61'b0, fmt}, 64'd1);
      ordy = 1'b1;
      step();
      chk("rel1_imm", {32'b0, imm}, 64'd8);
      chk("rel1_fmt", {61'b0, fmt}, 64'd3);
      chk("rel1_irdy", {63'b0, irdy}, 64'd1);
      step();
      iv = 1'b0;
      chk("rel2_imm", {32'b0, imm}, 64'hFFFFFFF8);
      chk("rel2_fmt", {61'b0, fmt}, 64'd3);
      chk("rel2_ov", {63'b0, ov}, 64'd1);
      step();
      chk("rel_nodup", {63'b0, ov}, 64'd0);

      // flush while FULL with a concurrent input
      ordy = 1'b0; iv = 1'b1; ins = 32'h00500113;
      step();
      ins = 32'h0040A423;
      step();
      chk("fl_full_irdy", {63'b0, irdy}, 64'd0);
      fl = 1'b1; ins = 32'hFE40AC23;
      step();
      fl = 1'b0; iv = 1'b0;
      chk("fl_ov", {63'b0, ov}, 64'd0);
      chk("fl_irdy", {63'b0, irdy}, 64'd1);
      ordy = 1'b1;
      step();
      chk("fl_gone1", {63'b0, ov}, 64'd0);
      step();
      chk("fl_gone2", {63'b0, ov}, 64'd0);

      // U and J formats
      iv = 1'b1; ins = 32'h123450B7;
      step();
      chk("lui_imm", {32'b0, imm}, LUI_IMM);
      chk("lui_fmt", {61'b0, fmt}, LUI_FMT);
      ins = 32'hFFDFF0EF;
      step();
      iv = 1'b0;
      chk("jal_imm", {32'b0, imm}, JAL_IMM);
      chk("jal_fmt", {61'b0, fmt}, JAL_FMT);
      step();

      // reset mid-operation while FULL
      ordy = 1'b0; iv = 1'b1; ins = 32'h00500113;
      step();
      step();
      iv = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_ov", {63'b0, ov}, 64'd0);
      chk("mrst_irdy", {63'b0, irdy}, 64'd1);
      chk("mrst_imm", {32'b0, imm}, 64'd0);
      ordy = 1'b1;
      step();
      chk("mrst_gone", {63'b0, ov}, 64'd0);

      // XLEN=64 instance
      ordy64 = 1'b1; iv64 = 1'b1; ins64 = 32'h03F01013;
      step();
      chk("slli64_imm", imm64, 64'h000000000000003F);
      chk("slli64_fmt", {61'b0, fmt64}, 64'd2);
      ins64 = 32'hFFF00093;
      step();
      chk("addi64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
      ins64 = 32'h123450B7;
      step();
      iv64 = 1'b0;
`ifdef IMM_GEN_UJ_EN
      chk("lui64_imm", imm64, 64'h0000000012345000);
`else
      chk("lui64_imm", imm64, 64'h0);
`endif
      step();
      ordy64 = 1'b0; iv64 = 1'b1; ins64 = 32'hFE000EE3;
      step();
      step();
      iv64 = 1'b0;
      chk("full64_irdy", {63'b0, irdy64}, 64'd0);
      chk("full64_imm", imm64, 64'hFFFFFFFFFFFFFFFC);
      rst64 = 1'b1;
      step();
      rst64 = 1'b0;
      chk("rst64_ov", {63'b0, ov64}, 64'd0);
      chk("rst64_imm", imm64, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush_i  input  1  discard all buffered and incoming entries.
REQ-005 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1) forming the upstream handshake; transfer when both high.
REQ-006 SHALL have port instr_i  input  32  raw RV instruction.
REQ-007 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1) forming the downstream handshake.
REQ-008 SHALL have port imm_o  output  XLEN  extended immediate.
REQ-009 SHALL have port fmt_o  output  3  format code: R=0, I=1, SH=2, S=3, B=4, U=5, J=6, ILL=7.

Function
REQ-010 SHALL decode opcode[6:0]: 0110011->R; 0010011 with funct3 001/101->SH; other 0010011, 0000011, 1100111->I; 0100011->S; 1100011->B; 0110111, 0010111->U; 1101111->J; anything else->ILL.
REQ-011 SHALL produce imm_o: R and ILL -> all zeros; I -> sext(instr[31:20]); SH -> zext(instr[24:20]) for XLEN=32, zext(instr[25:20]) for XLEN=64; S -> sext({instr[31:25],instr[11:7]}); B -> sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); U -> sext({instr[31:12],12'b0}); J -> sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); sext/zext to XLEN.
REQ-012 SHALL never drive X on any output.
REQ-013 SHALL buffer results in a 2-entry in-order skid buffer with states EMPTY, ONE, FULL.
REQ-014 SHALL drive in_ready_o = (state != FULL), registered (no combinational path from out_ready_i).
REQ-015 SHALL drive out_valid_o = (state != EMPTY); imm_o/fmt_o show the oldest entry and hold stable while out_valid_o high and out_ready_i low.
REQ-016 SHALL have latency 1: instruction accepted at edge N with state EMPTY appears on outputs after edge N.
REQ-017 SHALL transition: push only -> EMPTY->ONE, ONE->FULL; pop only -> FULL->ONE, ONE->EMPTY; simultaneous push and pop in ONE -> stays ONE, new entry queued behind; push with state FULL not possible (in_ready_o low).
REQ-018 SHALL sustain one transfer per cycle when out_ready_i stays high.
REQ-019 SHALL, with flush_i high, go to EMPTY at the next edge, ignoring any concurrent push or pop; flush has priority over both.

Reset
REQ-020 SHALL, with rst_i high at an edge, go to EMPTY: out_valid_o=0, in_ready_o=1, imm_o=0, fmt_o=0; reset has priority over flush and handshakes.
REQ-021 SHALL discard any in-flight entries when reset is asserted mid-operation; no entry emerges after reset.

Configuration
REQ-022 SHALL support macro IMM_GEN_UJ_EN: defined -> U and J decoded per REQ-011; undefined -> opcodes 0110111, 0010111, 1101111 yield fmt_o=ILL and imm_o=0.

Structure
REQ-023 SHALL place format codes, opcode constants and the state encoding in shared package imm_gen_pkg.
REQ-024 SHALL place the combinational decode/extend in sub-module imm_gen_decode (parameter XLEN); imm_gen_stage holds the buffer and FSM.

Verification
REQ-025 SHALL cover: XLEN=32, push 0xFFF00093 (addi -1), out_ready_i=1 -> next cycle imm_o=0xFFFFFFFF, fmt_o=1.
REQ-026 SHALL cover: push 0xFE000EE3 (beq, offset -4) -> imm_o=0xFFFFFFFC, fmt_o=4; push 0x40515093 (srai x1,x2,5) -> imm_o=0x00000005, fmt_o=2.
REQ-027 SHALL cover: out_ready_i=0, push 3 instructions back-to-back -> in_ready_o low after second push, third held; release out_ready_i -> outputs in order, no loss or duplication.
REQ-028 SHALL cover: state FULL, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, flushed input never appears.
REQ-029 SHALL cover: IMM_GEN_UJ_EN defined, push 0x123450B7 (lui) -> imm_o=0x12345000, fmt_o=5; undefined -> fmt_o=7, imm_o=0.
REQ-030 SHALL cover: XLEN=64, push 0x03F01013 (slli shamt 63) -> imm_o=0x000000000000003F; rst_i while FULL -> out_valid_o=0 next cycle.
